operand_collector: RTL and testbench

//  Sits between the warp scheduler issue port and the ALU/FPU datapath, in front of the banked register file.

---
 rtl/operand_collector.sv | 264 ++++++++++++++++++++++++++
 tb/tb_operand_collector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// operand_collector: buffers issued instructions in collector units, reads their
// source operands from a banked register file (one read per bank per cycle, with
// round-robin arbitration per bank) and dispatches fully collected instructions.
// Optional build macro OC_PERF_CNT_EN adds a saturating bank-conflict counter.
//
// CU state      | meaning
// CU_FREE       | unallocated, may accept an instruction
// CU_COLLECT    | waiting for one or more operand slots to fill
// CU_READY      | all operands held, waiting for (or sitting in) the output register
//
// Slot state    | meaning
// SL_FULL       | data valid (also used for disabled sources, data 0)
// SL_PEND       | needs a bank read, competing for its bank
// SL_FLY        | read granted, data arrives next cycle
// SL_DUP        | rs2 == rs1, filled from the same read as slot 0
module operand_collector #(
  parameter int NUM_CU     = 4,
  parameter int NUM_BANKS  = 4,
  parameter int REG_BITS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 16
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [REG_BITS-1:0]                                 in_rs1,
  input  logic [REG_BITS-1:0]                                 in_rs2,
  input  logic [1:0]                                          in_src_en,
  input  logic [TAG_W-1:0]                                    in_payload,
  output logic [NUM_BANKS-1:0]                                rf_rd_en,
  output logic [NUM_BANKS*(REG_BITS-$clog2(NUM_BANKS))-1:0]   rf_rd_off,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]                     rf_rd_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [DATA_WIDTH-1:0]                               out_op1,
  output logic [DATA_WIDTH-1:0]                               out_op2,
  output logic [TAG_W-1:0]                                    out_payload
`ifdef OC_PERF_CNT_EN
  ,
  output logic [31:0]                                         conflict_cnt
`endif
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int OFF_BITS  = REG_BITS - BANK_BITS;
  localparam int NUM_SLOTS = 2 * NUM_CU;
  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int CU_BITS   = $clog2(NUM_CU);

  localparam logic [1:0] CU_FREE    = 2'd0;
  localparam logic [1:0] CU_COLLECT = 2'd1;
  localparam logic [1:0] CU_READY   = 2'd2;

  localparam logic [1:0] SL_FULL = 2'd0;
  localparam logic [1:0] SL_PEND = 2'd1;
  localparam logic [1:0] SL_FLY  = 2'd2;
  localparam logic [1:0] SL_DUP  = 2'd3;

  logic [1:0]            cu_st      [NUM_CU];
  logic [TAG_W-1:0]      cu_payload [NUM_CU];
  logic [1:0]            sl_st      [NUM_SLOTS];
  logic [REG_BITS-1:0]   sl_reg     [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] sl_data    [NUM_SLOTS];
  logic [SLOT_BITS-1:0]  rr_ptr     [NUM_BANKS];
  logic [NUM_BANKS-1:0]  rd_pend;
  logic [SLOT_BITS-1:0]  rd_slot    [NUM_BANKS];
  logic [CU_BITS-1:0]    disp_ptr;
  logic [CU_BITS-1:0]    out_cu;

  logic [NUM_SLOTS-1:0]  req, gnt, cap;
  logic [NUM_BANKS-1:0]  gnt_any;
  logic [SLOT_BITS-1:0]  gnt_slot   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] data_now   [NUM_SLOTS];
  logic [NUM_CU-1:0]     free, ready_now;
  logic [CU_BITS-1:0]    alloc, sel_cu;
  logic                  sel_any;
  logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
  logic [TAG_W-1:0]      sel_pl;
  logic                  in_fire, out_fire, can_load;

  assign in_ready = rst_n && (|free);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign can_load = !out_valid || out_ready;

  // Per-bank round-robin grant among pending slots; drives the RF read strobes.
  always_comb begin
    int idx;
    idx      = 0;
    req      = '0;
    gnt      = '0;
    gnt_any  = '0;
    rf_rd_en = '0;
    rf_rd_off = '0;
    for (int b = 0; b < NUM_BANKS; b++) gnt_slot[b] = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      req[s] = (cu_st[s/2] == CU_COLLECT) && (sl_st[s] == SL_PEND);
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        idx = (int'(rr_ptr[b]) + i) % NUM_SLOTS;
        if (!gnt_any[b] && req[idx] && (sl_reg[idx][BANK_BITS-1:0] == BANK_BITS'(b))) begin
          gnt_any[b]  = 1'b1;
          gnt[idx]    = 1'b1;
          gnt_slot[b] = SLOT_BITS'(idx);
        end
      end
      if (gnt_any[b]) begin
        rf_rd_en[b] = 1'b1;
        rf_rd_off[b*OFF_BITS +: OFF_BITS] = sl_reg[gnt_slot[b]][REG_BITS-1:BANK_BITS];
      end
    end
  end

  // Slot data as it will be after this edge: returning reads (and their duplicates) overlay stored data.
  always_comb begin
    cap = '0;
    for (int s = 0; s < NUM_SLOTS; s++) data_now[s] = sl_data[s];
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_pend[b]) begin
        cap[rd_slot[b]]      = 1'b1;
        data_now[rd_slot[b]] = rf_rd_data[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int c = 0; c < NUM_CU; c++) begin
      if (cap[2*c] && (sl_st[2*c+1] == SL_DUP)) begin
        cap[2*c+1]      = 1'b1;
        data_now[2*c+1] = data_now[2*c];
      end
    end
  end

  // Allocation (lowest free CU) and dispatch pick (round-robin from the last dispatched CU).
  // A CU completing this cycle is already a candidate so out_valid follows the capture edge.
  always_comb begin
    int c;
    c         = 0;
    free      = '0;
    ready_now = '0;
    alloc     = '0;
    sel_any   = 1'b0;
    sel_cu    = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    sel_pl    = '0;
    for (int i = 0; i < NUM_CU; i++) begin
      free[i]      = (cu_st[i] == CU_FREE);
      ready_now[i] = (cu_st[i] == CU_READY) ||
                     ((cu_st[i] == CU_COLLECT) &&
                      ((sl_st[2*i] == SL_FULL) || cap[2*i]) &&
                      ((sl_st[2*i+1] == SL_FULL) || cap[2*i+1]));
    end
    for (int i = NUM_CU - 1; i >= 0; i--)
      if (free[i]) alloc = CU_BITS'(i);
    for (int i = 0; i < NUM_CU; i++) begin
      c = (int'(disp_ptr) + i) % NUM_CU;
      if (!sel_any && ready_now[c] && !(out_valid && (out_cu == CU_BITS'(c)))) begin
        sel_any = 1'b1;
        sel_cu  = CU_BITS'(c);
        sel_op1 = data_now[2*c];
        sel_op2 = data_now[2*c+1];
        sel_pl  = cu_payload[c];
      end
    end
  end

  // CU and slot state: accept, grant, capture, completion and release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CU; c++) begin
        cu_st[c]      <= CU_FREE;
        cu_payload[c] <= '0;
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
        sl_st[s]   <= SL_FULL;
        sl_reg[s]  <= '0;
        sl_data[s] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CU; c++) begin
        if (out_fire && (out_cu == CU_BITS'(c)))
          cu_st[c] <= CU_FREE;
        else if ((cu_st[c] == CU_COLLECT) && ready_now[c])
          cu_st[c] <= CU_READY;
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (gnt[s]) sl_st[s] <= SL_FLY;
        if (cap[s]) begin
          sl_st[s]   <= SL_FULL;
          sl_data[s] <= data_now[s];
        end
      end
      if (in_fire) begin
        cu_st[alloc]              <= CU_COLLECT;
        cu_payload[alloc]         <= in_payload;
        sl_reg[2*int'(alloc)]     <= in_rs1;
        sl_reg[2*int'(alloc)+1]   <= in_rs2;
        sl_data[2*int'(alloc)]    <= '0;
        sl_data[2*int'(alloc)+1]  <= '0;
        sl_st[2*int'(alloc)]      <= in_src_en[0] ? SL_PEND : SL_FULL;
        if (!in_src_en[1])
          sl_st[2*int'(alloc)+1] <= SL_FULL;
        else if (in_src_en[0] && (in_rs1 == in_rs2))
          sl_st[2*int'(alloc)+1] <= SL_DUP;
        else
          sl_st[2*int'(alloc)+1] <= SL_PEND;
      end
    end
  end

  // Read tracking: remember which slot each bank's returning data belongs to; advance RR pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rr_ptr[b]  <= '0;
        rd_slot[b] <= '0;
      end
    end else begin
      rd_pend <= gnt_any;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gnt_any[b]) begin
          rd_slot[b] <= gnt_slot[b];
          rr_ptr[b]  <= SLOT_BITS'((int'(gnt_slot[b]) + 1) % NUM_SLOTS);
        end
      end
    end
  end

  // Output register: loads a new instruction when empty or when the current one transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_payload <= '0;
      out_cu      <= '0;
      disp_ptr    <= '0;
    end else if (can_load) begin
      out_valid <= sel_any;
      if (sel_any) begin
        out_op1     <= sel_op1;
        out_op2     <= sel_op2;
        out_payload <= sel_pl;
        out_cu      <= sel_cu;
        disp_ptr    <= CU_BITS'((int'(sel_cu) + 1) % NUM_CU);
      end
    end
  end

`ifdef OC_PERF_CNT_EN
  logic lost;
  assign lost = |(req & ~gnt);

  // Saturating count of cycles where some pending slot lost its bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if (lost && (conflict_cnt != 32'hFFFF_FFFF))
      conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Testbench for operand_collector: directed scenarios plus randomized traffic,
// checked against a scoreboard keyed by payload and a behavioural RF model.
module tb_operand_collector;

  localparam int NB = 4;
  localparam int OFFB = 6;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_rs1, in_rs2;
  logic [1:0]     in_src_en;
  logic [15:0]    in_payload;
  logic [NB-1:0]  rf_rd_en;
  logic [NB*OFFB-1:0] rf_rd_off;
  logic [NB*DW-1:0]   rf_rd_data;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_op1, out_op2;
  logic [15:0]    out_payload;
`ifdef OC_PERF_CNT_EN
  logic [31:0]    conflict_cnt;
`endif

  operand_collector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_src_en(in_src_en), .in_payload(in_payload),
    .rf_rd_en(rf_rd_en), .rf_rd_off(rf_rd_off), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_payload(out_payload)
`ifdef OC_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // register file contents; reg index r lives in bank r%4 at offset r/4
  logic [DW-1:0] rf_mem [256];

  // RF model: data valid exactly one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      rf_rd_data[b*DW +: DW] <= rf_rd_en[b] ? rf_mem[int'(rf_rd_off[b*OFFB +: OFFB])*NB + b] : $urandom;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard keyed by payload low byte
  bit            exp_valid [256];
  logic [DW-1:0] exp_op1 [256];
  logic [DW-1:0] exp_op2 [256];
  logic [15:0]   exp_pl  [256];
  int n_issued = 0, n_disp = 0, exp_reads = 0, rd_total = 0, cyc = 0;
  logic [7:0] next_id = 8'd0;

  typedef struct {int cyc; int bank; int off;} rd_t;
  rd_t rd_log[$];

  logic          s_in_ready, s_out_valid, s_fire_in, s_fire_out;
  logic [DW-1:0] s_op1, s_op2;
  logic [15:0]   s_pl;
  logic [NB-1:0] s_rd_en;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_op1, held_op2;
  logic [15:0]   held_pl;
  logic          accepted;

  // one clock: sample at negedge, step past posedge, update the model
  task automatic tick();
    logic [7:0]  rs1, rs2;
    logic [1:0]  en;
    logic [15:0] pl;
    int id;
    @(negedge clk);
    s_in_ready = in_ready; s_out_valid = out_valid;
    s_op1 = out_op1; s_op2 = out_op2; s_pl = out_payload; s_rd_en = rf_rd_en;
    s_fire_in = in_valid && in_ready;
    s_fire_out = out_valid && out_ready;
    rs1 = in_rs1; rs2 = in_rs2; en = in_src_en; pl = in_payload;
    for (int b = 0; b < NB; b++)
      if (rf_rd_en[b]) begin
        rd_log.push_back('{cyc, b, int'(rf_rd_off[b*OFFB +: OFFB])});
        rd_total++;
      end
    if (stall_prev) begin
      check("hold_valid", s_out_valid, 1);
      check("hold_payload", s_pl, held_pl);
      check("hold_ops", {s_op1, s_op2}, {held_op1, held_op2});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_fire_in) begin
      id = int'(pl[7:0]);
      exp_valid[id] = 1'b1;
      exp_pl[id]  = pl;
      exp_op1[id] = en[0] ? rf_mem[rs1] : '0;
      exp_op2[id] = en[1] ? rf_mem[rs2] : '0;
      exp_reads += int'(en[0]) + int'(en[1] && !(en[0] && rs1 == rs2));
      n_issued++;
    end
    if (s_fire_out) begin
      id = int'(s_pl[7:0]);
      check("sb_known", exp_valid[id], 1);
      check("sb_payload", s_pl, exp_pl[id]);
      check("sb_op1", s_op1, exp_op1[id]);
      check("sb_op2", s_op2, exp_op2[id]);
      exp_valid[id] = 1'b0;
      n_disp++;
    end
    stall_prev = s_out_valid && !s_fire_out;
    held_pl = s_pl; held_op1 = s_op1; held_op2 = s_op2;
  endtask

  task automatic set_instr(input logic [7:0] rs1, input logic [7:0] rs2, input logic [1:0] en);
    in_rs1 = rs1; in_rs2 = rs2; in_src_en = en;
    in_payload = {8'($urandom), next_id};
    next_id++;
    in_valid = 1'b1;
  endtask

  task automatic issue(input logic [7:0] rs1, input logic [7:0] rs2, input logic [1:0] en);
    set_instr(rs1, rs2, en);
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      tick();
      accepted = s_fire_in;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max && lat < 0; i++) begin
      tick();
      if (s_out_valid) lat = i;
    end
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && n_disp < n_issued; i++) tick();
    check(tag, n_disp, n_issued);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_sent;
    logic [31:0] cc0;
    cc0 = '0;
    for (int i = 0; i < 256; i++) rf_mem[i] = $urandom;
    rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_src_en = '0;
    in_payload = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", rf_rd_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    check("post_rst_in_ready", s_in_ready, 1);
    check("post_rst_out_valid", s_out_valid, 0);

    // single instruction, no conflict
    rf_mem[8'h05] = 32'h1111; rf_mem[8'h0A] = 32'h2222;
    out_ready = 1'b1;
    issue(8'h05, 8'h0A, 2'b11);
    check("t1_accept", accepted, 1);
    wait_out(10, lat);
    check("t1_latency", lat, 3);
    drain("t1_drain");

    // bank conflict: both sources in bank 0
`ifdef OC_PERF_CNT_EN
    cc0 = conflict_cnt;
`endif
    rd_log.delete();
    issue(8'h04, 8'h08, 2'b11);
    check("t2_accept", accepted, 1);
    wait_out(12, lat);
    check("t2_latency", lat, 4);
    drain("t2_drain");
    check("t2_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("t2_bank_a", rd_log[0].bank, 0);
      check("t2_bank_b", rd_log[1].bank, 0);
      check("t2_off_a", rd_log[0].off, 1);
      check("t2_off_b", rd_log[1].off, 2);
      check("t2_consecutive", rd_log[1].cyc - rd_log[0].cyc, 1);
    end
`ifdef OC_PERF_CNT_EN
    check("t2_conflict_cnt", conflict_cnt - cc0, 1);
`endif

    // same register / disabled source
    rd_log.delete();
    issue(8'h07, 8'h07, 2'b11);
    check("t5_accept", accepted, 1);
    drain("t5_drain_a");
    check("t5_one_read", rd_log.size(), 1);
    if (rd_log.size() == 1) check("t5_bank3", rd_log[0].bank, 3);
    issue(8'h21, 8'h22, 2'b01);
    check("t5b_accept", accepted, 1);
    drain("t5_drain_b");

    // fill all CUs, then backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(8'($urandom), 8'($urandom), 2'b11);
      check("t3_fill_accept", accepted, 1);
    end
    set_instr(8'h13, 8'h2E, 2'b11);
    tick();
    check("t3_fifth_blocked", s_in_ready, 0);
    repeat (12) tick();
    check("t3_fifth_still_blocked", s_fire_in, 0);
    check("t4_out_valid", s_out_valid, 1);
    held_pl = s_pl;
    begin
      logic [15:0] first_pl;
      first_pl = s_pl;
      for (int k = 0; k < 10; k++) begin
        tick();
        check("t4_stable_pl", s_pl, first_pl);
      end
      out_ready = 1'b1;
      tick();
      check("t4_transfer", s_fire_out, 1);
      check("t3_no_ready_at_xfer", s_in_ready, 0);
      out_ready = 1'b0;
      tick();
      check("t3_fifth_accepted", s_fire_in, 1);
      check("t4_next_valid", s_out_valid, 1);
      check("t4_next_other", s_pl != first_pl, 1);
    end
    in_valid = 1'b0;
    drain("t3_drain");

    // randomized traffic
    rd_total = 0; exp_reads = 0; n_sent = 0;
    for (int c = 0; c < 4000 && n_sent < 150; c++) begin
      if (!in_valid && ($urandom % 3 != 0)) begin
        logic [7:0] r1;
        r1 = 8'($urandom);
        set_instr(r1, ($urandom % 4 == 0) ? r1 : 8'($urandom), 2'($urandom));
      end
      out_ready = ($urandom % 4) != 0;
      tick();
      if (s_fire_in) begin
        in_valid = 1'b0;
        n_sent++;
      end
    end
    check("rand_sent", n_sent, 150);
    drain("rand_drain");
    check("rand_rf_reads", rd_total, exp_reads);

    // reset in the cycle after a grant
    out_ready = 1'b1;
    issue(8'h11, 8'h00, 2'b01);
    tick();
    check("t6_grant", s_rd_en, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_rd_en", rf_rd_en, 0);
    check("t6_rst_in_ready", in_ready, 0);
    for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;
    n_issued = 0; n_disp = 0; stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_after_out_valid", s_out_valid, 0);
      check("t6_after_in_ready", s_in_ready, 1);
      check("t6_after_rd_en", s_rd_en, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
